// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard-to-ASCII path: set-2 scancodes,
// ASCII constants and the modifier state record.
package kbd_pkg;

    // Set-2 make codes of modifier and fixed-function keys
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_LCTRL  = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_TAB    = 8'h0D;
    localparam logic [7:0] SC_ESC    = 8'h76;

    // The front end reports 0x00 when no key is active
    localparam logic [7:0] SC_IDLE   = 8'h00;

    // ASCII constants
    localparam logic [7:0] ASC_NUL   = 8'h00;
    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_TAB   = 8'h09;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_ESC   = 8'h1B;
    localparam logic [7:0] ASC_SPACE = 8'h20;

    // Clearing this bit turns a lower-case letter into upper case
    localparam logic [7:0] ASC_CASE_BIT  = 8'h20;
    // Ctrl+letter keeps only the low five bits of the upper-case code
    localparam logic [7:0] ASC_CTRL_MASK = 8'h1F;

    // Modifier state tracked across key events
    typedef struct packed {
        logic lshift;
        logic rshift;
        logic ctrl;
        logic caps;
    } mod_state_t;

    // True for scancodes that only change modifier state
    function automatic logic is_modifier(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT) ||
               (code == SC_LCTRL)  || (code == SC_CAPS);
    endfunction

endpackage

// File: rtl/kbd_scan2ascii.sv
// Combinational set-2 make-code to ASCII translator. Applies Shift,
// CapsLock and Ctrl to the looked-up character; mapped=0 means the
// code has no character and nothing should be queued.
module kbd_scan2ascii
    import kbd_pkg::*;
(
    input  logic [7:0]  scancode,
    input  mod_state_t  mods,
    output logic [7:0]  ascii,
    output logic        mapped
);

    logic [7:0] letter;
    logic       is_letter;
    logic [7:0] sym_plain;
    logic [7:0] sym_shift;
    logic       is_sym;
    logic [7:0] fixed_char;
    logic       is_fixed;
    logic       shift;
    logic [7:0] upper;

    assign shift = mods.lshift | mods.rshift;
    assign upper = letter & ~ASC_CASE_BIT;

    // Letter keys, looked up as lower case
    always_comb begin
        letter    = ASC_NUL;
        is_letter = 1'b1;
        case (scancode)
            8'h1C: letter = "a";
            8'h32: letter = "b";
            8'h21: letter = "c";
            8'h23: letter = "d";
            8'h24: letter = "e";
            8'h2B: letter = "f";
            8'h34: letter = "g";
            8'h33: letter = "h";
            8'h43: letter = "i";
            8'h3B: letter = "j";
            8'h42: letter = "k";
            8'h4B: letter = "l";
            8'h3A: letter = "m";
            8'h31: letter = "n";
            8'h44: letter = "o";
            8'h4D: letter = "p";
            8'h15: letter = "q";
            8'h2D: letter = "r";
            8'h1B: letter = "s";
            8'h2C: letter = "t";
            8'h3C: letter = "u";
            8'h2A: letter = "v";
            8'h1D: letter = "w";
            8'h22: letter = "x";
            8'h35: letter = "y";
            8'h1A: letter = "z";
            default: is_letter = 1'b0;
        endcase
    end

    // Digit and punctuation keys with their shifted variants
    always_comb begin
        sym_plain = ASC_NUL;
        sym_shift = ASC_NUL;
        is_sym    = 1'b1;
        case (scancode)
            8'h16: begin sym_plain = "1";  sym_shift = "!"; end
            8'h1E: begin sym_plain = "2";  sym_shift = "@"; end
            8'h26: begin sym_plain = "3";  sym_shift = "#"; end
            8'h25: begin sym_plain = "4";  sym_shift = "$"; end
            8'h2E: begin sym_plain = "5";  sym_shift = "%"; end
            8'h36: begin sym_plain = "6";  sym_shift = "^"; end
            8'h3D: begin sym_plain = "7";  sym_shift = "&"; end
            8'h3E: begin sym_plain = "8";  sym_shift = "*"; end
            8'h46: begin sym_plain = "9";  sym_shift = "("; end
            8'h45: begin sym_plain = "0";  sym_shift = ")"; end
            8'h0E: begin sym_plain = 8'h60; sym_shift = "~"; end
            8'h4E: begin sym_plain = "-";  sym_shift = "_"; end
            8'h55: begin sym_plain = "=";  sym_shift = "+"; end
            8'h54: begin sym_plain = "[";  sym_shift = "{"; end
            8'h5B: begin sym_plain = "]";  sym_shift = "}"; end
            8'h5D: begin sym_plain = 8'h5C; sym_shift = "|"; end
            8'h4C: begin sym_plain = ";";  sym_shift = ":"; end
            8'h52: begin sym_plain = 8'h27; sym_shift = 8'h22; end
            8'h41: begin sym_plain = ",";  sym_shift = "<"; end
            8'h49: begin sym_plain = ".";  sym_shift = ">"; end
            8'h4A: begin sym_plain = "/";  sym_shift = "?"; end
            default: is_sym = 1'b0;
        endcase
    end

    // Keys whose character ignores all modifiers
    always_comb begin
        fixed_char = ASC_NUL;
        is_fixed   = 1'b1;
        case (scancode)
            SC_SPACE: fixed_char = ASC_SPACE;
            SC_ENTER: fixed_char = ASC_LF;
            SC_BKSP:  fixed_char = ASC_BS;
            SC_TAB:   fixed_char = ASC_TAB;
            SC_ESC:   fixed_char = ASC_ESC;
            default:  is_fixed = 1'b0;
        endcase
    end

    // Apply modifiers; Ctrl only alters letters
    always_comb begin
        ascii  = ASC_NUL;
        mapped = 1'b0;
        if (is_letter) begin
            mapped = 1'b1;
            if (mods.ctrl)
                ascii = upper & ASC_CTRL_MASK;
            else if (shift ^ mods.caps)
                ascii = upper;
            else
                ascii = letter;
        end else if (is_sym) begin
            mapped = 1'b1;
            ascii  = shift ? sym_shift : sym_plain;
        end else if (is_fixed) begin
            mapped = 1'b1;
            ascii  = fixed_char;
        end
    end

endmodule

// File: rtl/kbd_ascii_fifo.sv
// Keyboard event detector, modifier tracker and first-word-fall-through
// character FIFO feeding the CPU keyboard port.
module kbd_ascii_fifo
    import kbd_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    key_code,
    input  logic          key_down,
    input  logic          rd_en,
    input  logic          clr_ovf,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          shift_o,
    output logic          ctrl_o,
    output logic          caps_o
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [8:0]   pair_reg;
    logic         key_event;
    mod_state_t   mods_reg;
    mod_state_t   mods_next;
    logic [7:0]   xlat_char;
    logic         xlat_mapped;
    logic         push_req;

    logic [7:0]   mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         overflow_reg;
    logic         full;
    logic         do_pop;
    logic         do_push;
    logic         drop;

    // A new, non-idle pair is an event; holding a pair never repeats it
    assign key_event = ({key_code, key_down} != pair_reg) && (key_code != SC_IDLE);

    kbd_scan2ascii u_scan2ascii (
        .scancode (key_code),
        .mods     (mods_reg),
        .ascii    (xlat_char),
        .mapped   (xlat_mapped)
    );

    // Only make events of non-modifier keys with a mapping queue a character
    assign push_req = key_event && key_down && xlat_mapped && !is_modifier(key_code);

    // Sample the input pair every cycle, including idle pairs
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pair_reg <= 9'h000;
        else
            pair_reg <= {key_code, key_down};
    end

    // Modifier updates; CapsLock toggles on make and ignores break
    always_comb begin
        mods_next = mods_reg;
        if (key_event) begin
            case (key_code)
                SC_LSHIFT: mods_next.lshift = key_down;
                SC_RSHIFT: mods_next.rshift = key_down;
                SC_LCTRL:  mods_next.ctrl   = key_down;
                SC_CAPS:   if (key_down) mods_next.caps = ~mods_reg.caps;
                default:   ;
            endcase
        end
    end

    // Modifier state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mods_reg <= '0;
        else
            mods_reg <= mods_next;
    end

    assign shift_o = mods_reg.lshift | mods_reg.rshift;
    assign ctrl_o  = mods_reg.ctrl;
    assign caps_o  = mods_reg.caps;

    // Pointer MSB separates full from empty when the low bits match
    assign count    = wr_ptr_reg - rd_ptr_reg;
    assign rd_valid = (wr_ptr_reg != rd_ptr_reg);
    assign full     = (count == FULL_COUNT);
    assign do_pop   = rd_en && rd_valid;
    // A pop in the same cycle frees the slot the push needs
    assign do_push  = push_req && (!full || do_pop);
    assign drop     = push_req && full && !do_pop;

    // Head of queue shows through whenever the FIFO holds data
    assign rd_data  = rd_valid ? mem[rd_ptr_reg[AW-1:0]] : ASC_NUL;
    assign overflow = overflow_reg;

    // Character storage; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg[AW-1:0]] <= xlat_char;
    end

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Sticky overflow; a fresh drop beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow_reg <= 1'b0;
        else if (drop)
            overflow_reg <= 1'b1;
        else if (clr_ovf)
            overflow_reg <= 1'b0;
    end

endmodule
